// File: rtl/kb_ascii_decoder.sv
// Keyboard scan-code (set 2) to ASCII decoder. It tracks make/break and
// extended prefixes plus Shift/Ctrl/Caps state, and buffers translated
// characters in a small first-word-fall-through FIFO.
module kb_ascii_decoder #(
  parameter int W = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scan_done_tick,
  input  logic [7:0] scan_code,
  input  logic       rd_ascii,
  output logic [7:0] ascii_code,
  output logic       ascii_empty,
  output logic       shift_on,
  output logic       ctrl_on,
  output logic       caps_on,
  output logic       overflow_tick
);

  localparam int DEPTH = 2 ** W;

  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_e;

  state_e     state_q, state_d;
  logic       lshift_q, lshift_d, rshift_q, rshift_d;
  logic       lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic       caps_q, caps_d, caps_held_q, caps_held_d;
  logic       overflow_q, overflow_d;
  logic [W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0] fifo_mem [DEPTH];

  logic       push_req, do_push, do_pop, fifo_empty, fifo_full;
  logic [7:0] push_char;
  logic [8:0] xlat;

  // Translate a make code into {hit, ascii} using the current modifier state.
  function automatic logic [8:0] translate(input logic [7:0] code, input logic shift,
                                           input logic ctrl, input logic caps);
    logic [4:0] idx;
    logic       hit;
    logic [7:0] un, sh;
    idx = 5'd0;
    hit = 1'b0;
    un  = 8'h00;
    sh  = 8'h00;
    case (code)
      8'h1C: idx = 5'd1;   8'h32: idx = 5'd2;   8'h21: idx = 5'd3;   8'h23: idx = 5'd4;
      8'h24: idx = 5'd5;   8'h2B: idx = 5'd6;   8'h34: idx = 5'd7;   8'h33: idx = 5'd8;
      8'h43: idx = 5'd9;   8'h3B: idx = 5'd10;  8'h42: idx = 5'd11;  8'h4B: idx = 5'd12;
      8'h3A: idx = 5'd13;  8'h31: idx = 5'd14;  8'h44: idx = 5'd15;  8'h4D: idx = 5'd16;
      8'h15: idx = 5'd17;  8'h2D: idx = 5'd18;  8'h1B: idx = 5'd19;  8'h2C: idx = 5'd20;
      8'h3C: idx = 5'd21;  8'h2A: idx = 5'd22;  8'h1D: idx = 5'd23;  8'h22: idx = 5'd24;
      8'h35: idx = 5'd25;  8'h1A: idx = 5'd26;
      default: idx = 5'd0;
    endcase
    case (code)
      // digits: unshifted / shifted
      8'h45: {hit, un, sh} = {1'b1, 8'h30, 8'h29};
      8'h16: {hit, un, sh} = {1'b1, 8'h31, 8'h21};
      8'h1E: {hit, un, sh} = {1'b1, 8'h32, 8'h40};
      8'h26: {hit, un, sh} = {1'b1, 8'h33, 8'h23};
      8'h25: {hit, un, sh} = {1'b1, 8'h34, 8'h24};
      8'h2E: {hit, un, sh} = {1'b1, 8'h35, 8'h25};
      8'h36: {hit, un, sh} = {1'b1, 8'h36, 8'h5E};
      8'h3D: {hit, un, sh} = {1'b1, 8'h37, 8'h26};
      8'h3E: {hit, un, sh} = {1'b1, 8'h38, 8'h2A};
      8'h46: {hit, un, sh} = {1'b1, 8'h39, 8'h28};
      // punctuation, US layout
      8'h0E: {hit, un, sh} = {1'b1, 8'h60, 8'h7E};
      8'h4E: {hit, un, sh} = {1'b1, 8'h2D, 8'h5F};
      8'h55: {hit, un, sh} = {1'b1, 8'h3D, 8'h2B};
      8'h54: {hit, un, sh} = {1'b1, 8'h5B, 8'h7B};
      8'h5B: {hit, un, sh} = {1'b1, 8'h5D, 8'h7D};
      8'h5D: {hit, un, sh} = {1'b1, 8'h5C, 8'h7C};
      8'h4C: {hit, un, sh} = {1'b1, 8'h3B, 8'h3A};
      8'h52: {hit, un, sh} = {1'b1, 8'h27, 8'h22};
      8'h41: {hit, un, sh} = {1'b1, 8'h2C, 8'h3C};
      8'h49: {hit, un, sh} = {1'b1, 8'h2E, 8'h3E};
      8'h4A: {hit, un, sh} = {1'b1, 8'h2F, 8'h3F};
      // controls ignore every modifier
      8'h29: {hit, un, sh} = {1'b1, 8'h20, 8'h20};
      8'h5A: {hit, un, sh} = {1'b1, 8'h0D, 8'h0D};
      8'h66: {hit, un, sh} = {1'b1, 8'h08, 8'h08};
      8'h0D: {hit, un, sh} = {1'b1, 8'h09, 8'h09};
      8'h76: {hit, un, sh} = {1'b1, 8'h1B, 8'h1B};
      default: {hit, un, sh} = {1'b0, 8'h00, 8'h00};
    endcase
    if (idx != 5'd0) begin
      if (ctrl)              return {1'b1, 3'b000, idx};
      else if (shift ^ caps) return {1'b1, 8'h40 + {3'b000, idx}};
      else                   return {1'b1, 8'h60 + {3'b000, idx}};
    end
    return {hit, shift ? sh : un};
  endfunction

  assign shift_on      = lshift_q | rshift_q;
  assign ctrl_on       = lctrl_q | rctrl_q;
  assign caps_on       = caps_q;
  assign overflow_tick = overflow_q;

  // Prefix FSM and modifier tracking; produces at most one push request per byte.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch behind.
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lctrl_d     = lctrl_q;
    rctrl_d     = rctrl_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    push_req    = 1'b0;
    push_char   = 8'h00;
    xlat        = translate(scan_code, shift_on, ctrl_on, caps_q);
    if (scan_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          case (scan_code)
            8'hF0: state_d  = ST_BRK;
            8'hE0: state_d  = ST_EXT;
            8'h12: lshift_d = 1'b1;
            8'h59: rshift_d = 1'b1;
            8'h14: lctrl_d  = 1'b1;
            8'h58: begin
              // typematic repeats of Caps must not toggle again
              if (!caps_held_q) caps_d = ~caps_q;
              caps_held_d = 1'b1;
            end
            default: begin
              push_req  = xlat[8];
              push_char = xlat[7:0];
            end
          endcase
        end
        ST_BRK: begin
          case (scan_code)
            8'h12:   lshift_d    = 1'b0;
            8'h59:   rshift_d    = 1'b0;
            8'h14:   lctrl_d     = 1'b0;
            8'h58:   caps_held_d = 1'b0;
            default: ;
          endcase
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          case (scan_code)
            8'hF0: state_d = ST_EXT_BRK;
            8'h14: rctrl_d = 1'b1;
            8'h5A: begin push_req = 1'b1; push_char = 8'h0D; end
            8'h4A: begin push_req = 1'b1; push_char = 8'h2F; end
            default: ;
          endcase
        end
        default: begin  // ST_EXT_BRK
          if (scan_code == 8'h14) rctrl_d = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FIFO control: a pop frees the slot a simultaneous push into a full FIFO needs.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q == {~rd_ptr_q[W], rd_ptr_q[W-1:0]});
    do_pop     = rd_ascii & ~fifo_empty;
    do_push    = push_req & (~fifo_full | do_pop);
    overflow_d = push_req & fifo_full & ~do_pop;
    wr_ptr_d   = wr_ptr_q + (W+1)'(do_push);
    rd_ptr_d   = rd_ptr_q + (W+1)'(do_pop);
  end

  assign ascii_empty = fifo_empty;
  assign ascii_code  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q[W-1:0]];

  // State, modifier and pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Character storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    if (do_push) fifo_mem[wr_ptr_q[W-1:0]] <= push_char;
  end

endmodule

// File: tb/tb_kb_ascii_decoder.sv
// Self-checking bench for kb_ascii_decoder: directed scan-code sequences push
// expected characters into a scoreboard queue; a monitor drains the FIFO and
// compares each head against the queue.
module tb_kb_ascii_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scan_done_tick;
  logic [7:0] scan_code;
  logic       rd_ascii;
  logic [7:0] ascii_code;
  logic       ascii_empty;
  logic       shift_on, ctrl_on, caps_on, overflow_tick;

  logic       mon_rd, stim_rd, drain_en;
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  assign rd_ascii = mon_rd | stim_rd;

  kb_ascii_decoder #(.W(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .scan_done_tick(scan_done_tick),
    .scan_code     (scan_code),
    .rd_ascii      (rd_ascii),
    .ascii_code    (ascii_code),
    .ascii_empty   (ascii_empty),
    .shift_on      (shift_on),
    .ctrl_on       (ctrl_on),
    .caps_on       (caps_on),
    .overflow_tick (overflow_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
  endtask

  // Caller is at a negedge; returns at the following negedge (one-cycle tick).
  task automatic send(input logic [7:0] code);
    scan_code      = code;
    scan_done_tick = 1'b1;
    @(negedge clk);
    scan_done_tick = 1'b0;
  endtask

  task automatic send_exp(input logic [7:0] code, input logic [7:0] ch);
    exp_q.push_back(ch);
    send(code);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !ascii_empty) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_left"}, 8'(exp_q.size()), 8'h00);
    check({name, "_empty"}, 8'(ascii_empty), 8'h01);
  endtask

  // Monitor: compare and pop the head whenever the DUT presents a character.
  always @(negedge clk) begin
    if (drain_en && reset_n && !ascii_empty) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_char: got %02h, expected none", ascii_code);
      end else begin
        check("fifo_head", ascii_code, exp_q.pop_front());
      end
      mon_rd = 1'b1;
    end else begin
      mon_rd = 1'b0;
    end
  end

  initial begin
    reset_n = 1'b0; scan_done_tick = 1'b0; scan_code = 8'h00;
    stim_rd = 1'b0; drain_en = 1'b0; mon_rd = 1'b0;
    @(negedge clk);
    check("rst_empty", 8'(ascii_empty), 8'h01);
    check("rst_code",  ascii_code,       8'h00);
    check("rst_mods",  8'({shift_on, ctrl_on, caps_on}), 8'h00);
    check("rst_ovf",   8'(overflow_tick), 8'h00);
    @(negedge clk);
    reset_n  = 1'b1;
    drain_en = 1'b1;
    @(negedge clk);

    // make/break of A
    check("t1_pre_empty", 8'(ascii_empty), 8'h01);
    send_exp(8'h1C, 8'h61);
    check("t1_post_empty", 8'(ascii_empty), 8'h00);
    check("t1_post_code",  ascii_code,       8'h61);
    send(8'hF0); send(8'h1C);
    wait_drain("t1");

    // shift window
    send(8'h12);
    check("t2_shift_set", 8'(shift_on), 8'h01);
    send_exp(8'h1C, 8'h41);
    send_exp(8'h16, 8'h21);
    send(8'hF0);
    check("t2_shift_mid_brk", 8'(shift_on), 8'h01);
    send(8'h12);
    check("t2_shift_clr", 8'(shift_on), 8'h00);
    send_exp(8'h1C, 8'h61);
    wait_drain("t2");

    // caps lock with typematic repeat, shift inverts caps, punctuation/controls
    send(8'h58);
    check("t3_caps_on", 8'(caps_on), 8'h01);
    send(8'h58);
    check("t3_caps_rep", 8'(caps_on), 8'h01);
    send(8'hF0); send(8'h58);
    check("t3_caps_rel", 8'(caps_on), 8'h01);
    send_exp(8'h1C, 8'h41);
    send(8'h12);
    send_exp(8'h1C, 8'h61);
    send_exp(8'h45, 8'h29);
    send_exp(8'h4E, 8'h5F);
    send_exp(8'h52, 8'h22);
    send(8'hF0); send(8'h12);
    send(8'h58); send(8'hF0); send(8'h58);
    check("t3_caps_off", 8'(caps_on), 8'h00);
    send_exp(8'h4E, 8'h2D);
    send_exp(8'h0E, 8'h60);
    send_exp(8'h76, 8'h1B);
    send_exp(8'h66, 8'h08);
    send_exp(8'h0D, 8'h09);
    wait_drain("t3");

    // ctrl (right via E0, left plain), extended keys
    send(8'hE0); send(8'h14);
    check("t4_rctrl_on", 8'(ctrl_on), 8'h01);
    send_exp(8'h21, 8'h03);
    send(8'hE0); send(8'hF0); send(8'h14);
    check("t4_rctrl_off", 8'(ctrl_on), 8'h00);
    send(8'hE0); send_exp(8'h5A, 8'h0D);
    send(8'hE0); send(8'h74);
    send(8'h12);
    send(8'hE0); send_exp(8'h4A, 8'h2F);
    send(8'hF0); send(8'h12);
    send(8'h14);
    send_exp(8'h1A, 8'h1A);
    send_exp(8'h16, 8'h31);
    send(8'hF0); send(8'h14);
    check("t4_lctrl_off", 8'(ctrl_on), 8'h00);
    wait_drain("t4");

    // overflow with W=2 (depth 4)
    drain_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      send_exp(8'h29, 8'h20);
      check("t5_no_ovf", 8'(overflow_tick), 8'h00);
    end
    send(8'h29);
    check("t5_ovf_pulse", 8'(overflow_tick), 8'h01);
    @(negedge clk);
    check("t5_ovf_single", 8'(overflow_tick), 8'h00);
    stim_rd = 1'b1;
    check("t5_head_before_pop", ascii_code, exp_q.pop_front());
    send_exp(8'h29, 8'h20);
    stim_rd = 1'b0;
    check("t5_no_ovf_popush", 8'(overflow_tick), 8'h00);
    check("t5_still_full", 8'(ascii_empty), 8'h00);
    drain_en = 1'b1;
    wait_drain("t5");

    // reset between F0 and the next byte
    send(8'h12);
    send(8'hF0);
    reset_n = 1'b0;
    #1;
    check("t6_rst_mods",  8'({shift_on, ctrl_on, caps_on}), 8'h00);
    check("t6_rst_empty", 8'(ascii_empty), 8'h01);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_exp(8'h1C, 8'h61);
    wait_drain("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kb_ascii_decoder.md
# kb_ascii_decoder

Keyboard stream decoder between the PS/2 byte receiver and the UART transmit path. It consumes raw scan-code set 2 bytes, tracks make/break, extended prefixes and modifier state (Shift, Ctrl, Caps Lock), and translates key presses to ASCII. Characters are buffered in a small first-word-fall-through FIFO read with the same handshake the UART write side uses.

## Interface
- `W`, default 2: FIFO address bits; depth is 2**W characters.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `scan_done_tick` in 1: one-cycle strobe; `scan_code` is valid in that cycle.
- `scan_code` in 8: received PS/2 byte.
- `rd_ascii` in 1: pop the FIFO head; ignored when empty.
- `ascii_code` out 8: FIFO head (fall-through); 0x00 when empty.
- `ascii_empty` out 1: FIFO empty.
- `shift_on` out 1: either Shift held.
- `ctrl_on` out 1: either Ctrl held.
- `caps_on` out 1: Caps Lock toggle state.
- `overflow_tick` out 1: one-cycle pulse when a character is dropped because the FIFO is full.

## Operation
- FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0). Only cycles with `scan_done_tick` advance the FSM.
- IDLE:
  - F0 -> BRK; E0 -> EXT.
  - 12 or 59 sets `lshift`/`rshift`. 14 sets `lctrl`.
  - 58 toggles `caps_on` only if `caps_held`=0, then sets `caps_held`.
  - Translatable code pushes one character. Any other code is ignored. The FSM stays in IDLE.
- BRK: 12/59 clear the matching shift; 14 clears `lctrl`; 58 clears `caps_held`; anything else is ignored. -> IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - 14 sets `rctrl`.
  - 5A (keypad Enter) pushes 0x0D.
  - 4A (keypad /) pushes 0x2F.
  - Other codes are ignored.
  - -> IDLE, except on F0.
- EXT_BRK: 14 clears `rctrl`; anything else is ignored. -> IDLE.
- `shift_on` = lshift|rshift. `ctrl_on` = lctrl|rctrl.
- Letters (1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z):
  - Uppercase if `shift_on` XOR `caps_on`, else lowercase.
  - If `ctrl_on`: code = letter index 0x01..0x1A, with Shift and Caps ignored.
- Digits (45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9): unshifted gives the digit. Shift gives ) ! @ # $ % ^ & * ( respectively. Caps has no effect.
- Punctuation, US layout, unshifted/shifted:
  - 0E `/~, 4E -/_, 55 =/+, 54 [/{, 5B ]/}, 5D \/|.
  - 4C ;/:, 52 '/", 41 ,/<, 49 ./>, 4A //?.
  - Ctrl has no effect on digits or punctuation.
- Controls, modifier-independent: 29 0x20, 5A 0x0D, 66 0x08, 0D 0x09, 76 0x1B.
- Typematic repeats of a make code push repeated characters. Repeats of 58 do not re-toggle Caps.
- FIFO:
  - Push when full: the character is dropped, `overflow_tick` pulses, and contents are unchanged.
  - Push and pop in the same cycle when full: both happen and no overflow is reported.
  - Pop when empty is ignored. Pop and push in the same cycle when empty: the push lands.
  - Pointers wrap modulo 2**W.

## Timing
- Reset (async assert, sync release):
  - FSM in IDLE.
  - All modifier flags and `caps_held` = 0; `caps_on`, `shift_on`, `ctrl_on` = 0.
  - FIFO empty, so `ascii_empty`=1 and `ascii_code`=0x00.
  - `overflow_tick`=0.
- `scan_done_tick` in cycle N:
  - FSM, modifiers and FIFO update at the end of cycle N.
  - In cycle N+1: `ascii_empty`=0 and `ascii_code` = new character when the FIFO was empty; modifier outputs show the new value; `overflow_tick` is high for the single cycle N+1 when a drop occurred.
- Translation uses the modifier state held before the edge of cycle N. A modifier and a character can never arrive in the same byte.
- `rd_ascii` in cycle M: the head advances at the end of cycle M; the new head or empty status is visible in M+1.
- Back-to-back `scan_done_tick` on consecutive cycles must be handled with no loss.
- Reset mid-sequence (e.g. after F0) returns to IDLE; the next byte is treated as a make code.

## Test plan
- Reset, then feed 1C, F0, 1C -> exactly one character 0x61; `ascii_empty` 1 -> 0 one cycle after the 1C tick; after `rd_ascii`, `ascii_empty`=1.
- Feed 12, 1C, 16, F0 12, 1C -> FIFO holds 0x41, 0x21, 0x61; `shift_on` high from the cycle after 12 until the cycle after the F0 12 pair.
- Feed 58, 58, F0 58, 1C, 12, 1C -> `caps_on`=1 (repeat ignored); characters 0x41, 0x61.
- Feed E0 14, 21, E0 F0 14, E0 5A, E0 74 -> characters 0x03, 0x0D; `ctrl_on` back to 0; E0 74 pushes nothing.
- With W=2, feed 5×29 with no reads -> 4 entries, `overflow_tick` pulses on the 5th; then assert `rd_ascii` together with a 6th 29 tick -> still 4 entries, no overflow pulse.
- Assert `reset_n`=0 between F0 and 1C, then feed 1C -> 0x61 is pushed, state IDLE, modifier outputs 0.
